// File: rtl/mips_load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory: lane select,
// sign/zero extension, read-modify-write for sb/sh. Optional LSU_WORD_BUFFER_EN adds a last-write word buffer.
module mips_load_store_unit #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        done,
   output logic [31:0] load_data,
   output logic        addr_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_sig_read,
   output logic        mem_sig_write,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] idx_r, idx_n, req_idx;
   logic [1:0]            lane_r, lane_n, size_r, size_n;
   logic                  uns_r, uns_n, wr_r, wr_n;
   logic [15:0]           wdata_r, wdata_n;
   logic                  req_ready_n, done_n, addr_error_n, rd_n, wr_strobe_n;
   logic [31:0]           load_data_n, mem_address_n, mem_write_data_n;
   logic                  req_err, hit;
   logic [31:0]           hit_word;

   function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lane[1] ? w[31:16] : w[15:0];
      case (size)
         2'b00:   lane_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   lane_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: lane_extract = w;
      endcase
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [15:0] d,
                                              input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] r;
      r = w;
      if (size == 2'b00) begin
         case (lane)
            2'd0:    r[7:0]   = d[7:0];
            2'd1:    r[15:8]  = d[7:0];
            2'd2:    r[23:16] = d[7:0];
            default: r[31:24] = d[7:0];
         endcase
      end else if (lane[1]) begin
         r[31:16] = d;
      end else begin
         r[15:0] = d;
      end
      return r;
   endfunction

   assign req_idx = req_addr[ADDR_WIDTH+1:2];
   assign req_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                    ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

`ifdef LSU_WORD_BUFFER_EN
   logic                  buf_vld;
   logic [ADDR_WIDTH-1:0] buf_idx;
   logic [31:0]           buf_word;

   // Tracks whatever word the next WRITE cycle will put on the bus.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_vld  <= 1'b0;
         buf_idx  <= '0;
         buf_word <= '0;
      end else if (wr_strobe_n) begin
         buf_vld  <= 1'b1;
         buf_idx  <= idx_n;
         buf_word <= mem_write_data_n;
      end
   end

   assign hit      = buf_vld && (buf_idx == req_idx);
   assign hit_word = buf_word;
`else
   assign hit      = 1'b0;
   assign hit_word = 32'd0;
`endif

   always_comb begin
      state_n          = state;
      idx_n            = idx_r;
      lane_n           = lane_r;
      size_n           = size_r;
      uns_n            = uns_r;
      wr_n             = wr_r;
      wdata_n          = wdata_r;
      done_n           = 1'b0;
      addr_error_n     = 1'b0;
      rd_n             = 1'b0;
      wr_strobe_n      = 1'b0;
      load_data_n      = load_data;
      mem_address_n    = 32'd0;
      mem_write_data_n = 32'd0;
      case (state)
         IDLE: if (req_valid) begin
            idx_n   = req_idx;
            lane_n  = req_addr[1:0];
            size_n  = req_size;
            uns_n   = req_unsigned;
            wr_n    = req_write;
            wdata_n = req_wdata[15:0];
            if (req_err) begin
               state_n      = DONE;
               done_n       = 1'b1;
               addr_error_n = 1'b1;
               load_data_n  = 32'd0;
            end else if (req_write && req_size == 2'b10) begin
               state_n          = WRITE;
               wr_strobe_n      = 1'b1;
               mem_address_n    = 32'(req_idx);
               mem_write_data_n = req_wdata;
            end else if (hit && !req_write) begin
               state_n     = DONE;
               done_n      = 1'b1;
               load_data_n = lane_extract(hit_word, req_addr[1:0], req_size, req_unsigned);
            end else if (hit) begin
               state_n          = WRITE;
               wr_strobe_n      = 1'b1;
               mem_address_n    = 32'(req_idx);
               mem_write_data_n = lane_merge(hit_word, req_wdata[15:0], req_addr[1:0], req_size);
            end else begin
               state_n       = READ;
               rd_n          = 1'b1;
               mem_address_n = 32'(req_idx);
            end
         end
         // The read word is consumed straight off the bus at the closing edge.
         READ: if (wr_r) begin
            state_n          = WRITE;
            wr_strobe_n      = 1'b1;
            mem_address_n    = 32'(idx_r);
            mem_write_data_n = lane_merge(mem_read_data, wdata_r, lane_r, size_r);
         end else begin
            state_n     = DONE;
            done_n      = 1'b1;
            load_data_n = lane_extract(mem_read_data, lane_r, size_r, uns_r);
         end
         WRITE: begin
            state_n     = DONE;
            done_n      = 1'b1;
            load_data_n = 32'd0;
         end
         default: state_n = IDLE;
      endcase
      req_ready_n = (state_n == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         idx_r          <= '0;
         lane_r         <= 2'd0;
         size_r         <= 2'd0;
         uns_r          <= 1'b0;
         wr_r           <= 1'b0;
         wdata_r        <= 16'd0;
         req_ready      <= 1'b1;
         done           <= 1'b0;
         addr_error     <= 1'b0;
         load_data      <= 32'd0;
         mem_address    <= 32'd0;
         mem_write_data <= 32'd0;
         mem_sig_read   <= 1'b0;
         mem_sig_write  <= 1'b0;
      end else begin
         state          <= state_n;
         idx_r          <= idx_n;
         lane_r         <= lane_n;
         size_r         <= size_n;
         uns_r          <= uns_n;
         wr_r           <= wr_n;
         wdata_r        <= wdata_n;
         req_ready      <= req_ready_n;
         done           <= done_n;
         addr_error     <= addr_error_n;
         load_data      <= load_data_n;
         mem_address    <= mem_address_n;
         mem_write_data <= mem_write_data_n;
         mem_sig_read   <= rd_n;
         mem_sig_write  <= wr_strobe_n;
      end
   end

endmodule

// File: doc/mips_load_store_unit.md
Name: mips_load_store_unit

Overview:
- Sits between the ALU/control path and the word-addressed data memory.
- Converts byte-address load/store requests (lb/lbu/lh/lhu/lw/sb/sh/sw) into word accesses: selects lanes, sign/zero-extends loads, and performs read-modify-write for sub-word stores.
- Stalls the core through a ready/done handshake until the access completes.

Parameters:
- ADDR_WIDTH, 8, width of the memory word index (memory holds 2^ADDR_WIDTH 32-bit words).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the value is taken from the low bits.
- done  out  1  one-cycle pulse when the request completes.
- load_data  out  32  extended load result; valid while done=1 for loads.
- addr_error  out  1  qualifies done: misaligned, out of range, or reserved size.
- mem_address  out  32  word index = req_addr[ADDR_WIDTH+1:2], zero-extended.
- mem_write_data  out  32  full word to memory.
- mem_sig_read  out  1  memory read strobe.
- mem_sig_write  out  1  memory write strobe.
- mem_read_data  in  32  word returned by memory.

Behaviour:
- Reset values: every output and register is 0, except req_ready, which is 1. State = IDLE.
- Acceptance:
  - A request is accepted at a rising edge when req_valid=1 and state=IDLE.
  - addr, size, unsigned, write and wdata are latched at that edge.
  - Request inputs are ignored while not in IDLE.
- Error check at accept. addr_error is set when any of these holds:
  - size=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]≠00;
  - addr[31:ADDR_WIDTH+2]≠0.
- On error: no memory strobe ever asserts; next state is DONE with addr_error=1 and load_data=0.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE→READ: load, or sub-word store.
  - IDLE→WRITE: word store.
  - IDLE→DONE: error.
  - READ→DONE: load.
  - READ→WRITE: sub-word store.
  - WRITE→DONE.
  - DONE→IDLE unconditionally.
- READ state:
  - mem_sig_read=1 and mem_address driven for exactly one cycle.
  - mem_read_data is captured into a word register at the closing edge.
- WRITE state:
  - mem_sig_write=1 for exactly one cycle.
  - Word store: mem_write_data = wdata.
  - Sub-word store: mem_write_data = captured word with only the target lane replaced.
    - Byte lane = addr[1:0]; byte 0 = bits [7:0].
    - Half lane = addr[1]; half 0 = bits [15:0].
- Strobes and mem_address are registered; they are never asserted together and are 0 outside READ/WRITE.
- DONE state:
  - done=1 for one cycle.
  - Loads: load_data = selected lane, sign- or zero-extended per the latched unsigned bit; load_data holds until the next DONE.
  - Stores: load_data = 0.
- Latency from the accept edge to done high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- req_ready is high in IDLE only, so back-to-back requests are separated by at least one IDLE cycle after DONE.
- Reset asserted mid-operation aborts the request immediately. No further strobes; a partially completed read-modify-write is dropped; done is not pulsed.

Optional Feature:
- Macro: LSU_WORD_BUFFER_EN.
- Defined:
  - A one-entry buffer holds {valid, word index, word} of the last word written to memory.
  - A load or sub-word store whose index matches a valid entry skips READ: load IDLE→DONE (1 cycle), sub-word store IDLE→WRITE (2 cycles).
  - Every WRITE updates the buffer; reset clears valid.
- Undefined: no buffer; latencies exactly as listed in Behaviour.

Test Plan:
- Memory word 4 = 32'h80FF_7F01. lb at addr 0x12 → done 2 cycles after accept, load_data = 32'hFFFF_FFFF. lbu at 0x13 → 32'h0000_0080.
- lh at 0x10 → 32'h0000_7F01. lh at 0x12 → 32'hFFFF_80FF. lw at 0x10 → 32'h80FF_7F01; only one read strobe per access.
- sb data 8'hAA at 0x11 → one read, then one write of 32'h80FF_AA01 to index 4; done 3 cycles after accept.
- sh at 0x13, lw at 0x11, and lw at byte address 0x400 (ADDR_WIDTH=8) → each: addr_error=1, done 1 cycle after accept, no strobes.
- Assert reset in the WRITE cycle of a sub-word store → outputs return to reset values immediately, no done pulse, req_ready=1 after release.
- LSU_WORD_BUFFER_EN defined: sw 32'h1234_5678 to 0x20, then lbu 0x21 → no read strobe, load_data = 32'h0000_0056, done 1 cycle after accept.
